// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: access-size encodings,
// the responder FSM state type and a lane-alignment helper.
package mem_responder_pkg;

    localparam logic [1:0] SIZE_WORD    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_BYTE    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Force the byte lane to the natural alignment of the access size.
    function automatic logic [1:0] natural_lane(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [1:0] lane;
        case (size)
            SIZE_BYTE: lane = addr_lo;
            SIZE_HALF: lane = {addr_lo[1], 1'b0};
            default:   lane = 2'b00;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Little-endian lane handling: extracts a zero-extended byte/halfword/word
// from a stored word for loads, and splices store data into the addressed
// lanes of the stored word for stores.
module mem_byte_merge
    import mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    // Lane extraction and merge; untouched lanes keep the stored word.
    always_comb begin
        load_data = '0;
        merged    = word_in;
        case (size)
            SIZE_BYTE: begin
                load_data[7:0]               = word_in[{lane, 3'b000} +: 8];
                merged[{lane, 3'b000} +: 8]  = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data[15:0]                  = word_in[{lane[1], 4'b0000} +: 16];
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word_in;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory answering CPU load/store requests after a fixed
// number of wait states. Optional feature macro MEM_RESPONDER_ALIGN_CHECK_EN:
// when defined, misaligned or illegal-size accesses are rejected with
// resp_err; when undefined, addresses are masked to natural alignment and
// the illegal size behaves as a word access.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;

    state_t          state;
    logic [2:0]      count;
    logic            r_write;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            go_resp;
    logic            sel_write;
    logic [1:0]      sel_size;
    logic [AW-1:0]   sel_addr;
    logic [31:0]     sel_wdata;
    logic [1:0]      eff_size;
    logic [1:0]      eff_lane;
    logic            acc_err;
    logic [31:0]     cur_word;
    logic [31:0]     load_data;
    logic [31:0]     merged_word;

    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW];
    assign accept           = req_valid && req_ready;

    // Operate on the live request while idle, otherwise on the captured copy.
    always_comb begin
        sel_write = r_write;
        sel_size  = r_size;
        sel_addr  = r_addr;
        sel_wdata = r_wdata;
        if (state == IDLE) begin
            sel_write = req_write;
            sel_size  = req_size;
            sel_addr  = req_addr[AW-1:0];
            sel_wdata = req_wdata;
        end
    end

    // Decide the effective size/lane and whether the access is rejected.
    always_comb begin
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        acc_err  = (sel_size == SIZE_ILLEGAL) ||
                   ((sel_size == SIZE_HALF) && sel_addr[0]) ||
                   ((sel_size == SIZE_WORD) && (sel_addr[1:0] != 2'b00));
        eff_size = sel_size;
        eff_lane = sel_addr[1:0];
`else
        acc_err  = 1'b0;
        eff_size = (sel_size == SIZE_ILLEGAL) ? SIZE_WORD : sel_size;
        eff_lane = natural_lane(eff_size, sel_addr[1:0]);
`endif
    end

    assign cur_word = mem[sel_addr[AW-1:2]];

    mem_byte_merge u_merge (
        .size      (eff_size),
        .lane      (eff_lane),
        .word_in   (cur_word),
        .wdata     (sel_wdata),
        .load_data (load_data),
        .merged    (merged_word)
    );

    // Entry into RESP: straight from IDLE with no wait states, or when the
    // wait counter runs out.
    always_comb begin
        go_resp = 1'b0;
        case (state)
            IDLE:    go_resp = accept && (WAIT_CYCLES == 0);
            WAIT:    go_resp = (count == 3'd0);
            default: go_resp = 1'b0;
        endcase
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            r_write    <= 1'b0;
            r_size     <= SIZE_WORD;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_write   <= req_write;
                        r_size    <= req_size;
                        r_addr    <= req_addr[AW-1:0];
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            count <= 3'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (count != 3'd0) begin
                        count <= count - 3'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (go_resp) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (sel_write || acc_err) ? 32'd0 : load_data;
            end
        end
    end

    // Store commit at the end of the RESP cycle; reset aborts the write and
    // never touches the stored contents.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && r_write && !resp_err) begin
            mem[r_addr[AW-1:2]] <= merged_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (1, 3 and 0 wait
// states). Stimulus pushes expected responses; a negedge monitor pops and
// compares data, error flag and arrival cycle.
module tb_mem_responder;
    import mem_responder_pkg::*;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp acceptances and responses.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        mem_responder #(.WAIT_CYCLES(WC), .DEPTH_WORDS(64)) dut (
            .clk        (clk),
            .reset      (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_size   (req_size[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    function automatic int waitOf(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int g, input logic [31:0] rd, input logic err, input int due);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.due   = due;
        case (g)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic checkOutput(input int g);
        exp_t e;
        bit   have = 1'b0;
        case (g)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_resp[%0d]: got resp_valid=1 at cycle %0d, expected none", g, cyc);
        end else begin
            compare($sformatf("rdata[%0d]", g), resp_rdata[g], e.rdata);
            compare($sformatf("err[%0d]", g), {31'b0, resp_err[g]}, {31'b0, e.err});
            compare($sformatf("latency[%0d]", g), 32'(cyc), 32'(e.due));
        end
    endtask

    // Monitor: every presented response is checked against the scoreboard.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (resp_valid[g] === 1'b1) checkOutput(g);
        end
    end

    task automatic applyStimulus(input int g, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] exp_rd, input logic exp_err,
                                 input bit track);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[g] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ready_timeout[%0d]: got req_ready=0 for 40 cycles, expected 1", g);
            return;
        end
        req_write[g] = wr;
        req_size[g]  = sz;
        req_addr[g]  = addr;
        req_wdata[g] = wd;
        req_valid[g] = 1'b1;
        if (track) pushExp(g, exp_rd, exp_err, cyc + 1 + waitOf(g));
        @(negedge clk);
        req_valid[g] = 1'b0;
        req_write[g] = ~wr;
        req_size[g]  = SIZE_BYTE;
        req_addr[g]  = 32'hFFFF_FFFC;
        req_wdata[g] = 32'h0BAD_0BAD;
    endtask

    initial begin
        bit got;
        for (int g = 0; g < 3; g++) begin
            rst[g]       = 1'b1;
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_size[g]  = SIZE_WORD;
            req_addr[g]  = '0;
            req_wdata[g] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            compare($sformatf("reset_ready[%0d]", g), {31'b0, req_ready[g]}, 32'd1);
            compare($sformatf("reset_valid[%0d]", g), {31'b0, resp_valid[g]}, 32'd0);
            compare($sformatf("reset_err[%0d]", g), {31'b0, resp_err[g]}, 32'd0);
            compare($sformatf("reset_rdata[%0d]", g), resp_rdata[g], 32'd0);
            rst[g] = 1'b0;
        end

        // Instance 0: one wait state, lane handling, alignment, wrap.
        applyStimulus(0, 1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, SIZE_BYTE, 32'h12, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_HALF, 32'h12, 32'h0, 32'h0000DEAA, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        compare("rdata_hold[0]", resp_rdata[0], 32'h0000DEAA);
        applyStimulus(0, 1'b0, SIZE_BYTE, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, SIZE_WORD, 32'h11, 32'h12345678, 32'h0, CHK, 1'b1);
        applyStimulus(0, 1'b0, SIZE_WORD, 32'h10, 32'h0,
                      CHK ? 32'hDEAABEEF : 32'h12345678, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_HALF, 32'h13, 32'h0,
                      CHK ? 32'h0 : 32'h00001234, CHK, 1'b1);
        applyStimulus(0, 1'b0, SIZE_ILLEGAL, 32'h10, 32'h0,
                      CHK ? 32'h0 : 32'h12345678, CHK, 1'b1);
        applyStimulus(0, 1'b0, SIZE_BYTE, 32'h11, 32'h0,
                      CHK ? 32'h000000BE : 32'h00000056, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, SIZE_WORD, 32'h100, 32'h00000055, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_WORD, 32'h000, 32'h0, 32'h00000055, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, SIZE_HALF, 32'h2, 32'h1234BEEF, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_WORD, 32'h0, 32'h0, 32'hBEEF0055, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_HALF, 32'h0, 32'h0, 32'h00000055, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, SIZE_BYTE, 32'h3, 32'h0, 32'h000000BE, 1'b0, 1'b1);

        // Instance 1: three wait states, reset aborts a store in WAIT.
        applyStimulus(1, 1'b1, SIZE_WORD, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, SIZE_WORD, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        compare("abort_ready[1]", {31'b0, req_ready[1]}, 32'd1);
        compare("abort_valid[1]", {31'b0, resp_valid[1]}, 32'd0);
        compare("abort_rdata[1]", resp_rdata[1], 32'd0);
        repeat (5) @(negedge clk);
        applyStimulus(1, 1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, SIZE_HALF, 32'h22, 32'hAAAA5566, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h55663344, 1'b0, 1'b1);

        // Instance 2: zero wait states, request held valid back to back.
        applyStimulus(2, 1'b1, SIZE_WORD, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[2] === 1'b1) got = 1'b1;
        end
        compare("b2b_idle[2]", {31'b0, got}, 32'd1);
        req_write[2] = 1'b0;
        req_size[2]  = SIZE_WORD;
        req_addr[2]  = 32'h8;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            compare($sformatf("b2b_ready[%0d]", i), {31'b0, req_ready[2]}, 32'((i % 2) == 0));
            if ((i % 2) == 0) pushExp(2, 32'hCAFEF00D, 1'b0, cyc + 1);
            @(negedge clk);
        end
        req_valid[2] = 1'b0;

        // Drain: every expected response must have arrived.
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d/%0d/%0d pending responses, expected 0/0/0",
                     q0.size(), q1.size(), q2.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1; wait states inserted before response, legal 0..7.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64; storage size in 32-bit words, power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified for sub-word stores.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load data, zero-extended, right-justified.
REQ-013 SHALL have port resp_err  output  1  access rejected; valid only with resp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-016 SHALL register write, size, addr and wdata on acceptance; later input changes SHALL be ignored until return to IDLE.
REQ-017 On acceptance SHALL go to WAIT when WAIT_CYCLES>0, else straight to RESP.
REQ-018 SHALL stay in WAIT exactly WAIT_CYCLES cycles, using a 3-bit down-counter.
REQ-019 SHALL assert resp_valid for exactly the one RESP cycle, then return to IDLE; total latency acceptance-edge to resp_valid = WAIT_CYCLES+1 cycles.
REQ-020 SHALL index storage with addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored (address wraps).
REQ-021 SHALL use little-endian byte lanes: byte n of a word at addr[1:0]=n.
REQ-022 Loads SHALL return the addressed byte or halfword zero-extended into resp_rdata; word loads return the full word.
REQ-023 Stores SHALL modify only the addressed lanes, taking data from req_wdata[7:0] or [15:0]; the write SHALL commit on the RESP-cycle edge.
REQ-024 resp_rdata SHALL be 0 for stores and errors, and SHALL hold its value outside RESP.
REQ-025 A load in RESP SHALL see every store completed in an earlier transaction.

Reset
REQ-026 reset SHALL force IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=1 on the following cycle.
REQ-027 reset SHALL abort an in-flight request: no write commits and no resp_valid is issued.
REQ-028 reset SHALL NOT clear storage contents.

Configuration
REQ-029 With MEM_RESPONDER_ALIGN_CHECK_EN defined: halfword with addr[0]=1, word with addr[1:0]!=0, or req_size=11 SHALL produce resp_err=1, rdata=0 and no storage change.
REQ-030 Without MEM_RESPONDER_ALIGN_CHECK_EN: address low bits SHALL be masked to natural alignment, size 11 treated as word, resp_err tied 0.

Structure
REQ-031 Package mem_responder_pkg SHALL hold the size encodings (SIZE_WORD/HALF/BYTE) and the FSM state typedef.
REQ-032 SHALL contain one combinational sub-module, mem_byte_merge, for lane extraction on loads and lane merge on stores.

Verification
REQ-033 WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-034 After REQ-033: store byte 0xAA @0x12, load word @0x10 -> 0xDEAABEEF; load half @0x12 -> 0x0000DEAA.
REQ-035 ALIGN_CHECK_EN: store word @0x11 with data 0x12345678 -> err=1, rdata=0; following load @0x10 unchanged (0xDEAABEEF).
REQ-036 DEPTH_WORDS=64: store 0x00000055 @0x100, load @0x000 -> 0x00000055 (wrap).
REQ-037 Assert reset in WAIT of a store of 0xFFFFFFFF @0x20 (WAIT_CYCLES=3) -> no resp_valid, req_ready=1 next cycle, load @0x20 returns the prior value.
REQ-038 WAIT_CYCLES=0 with req_valid held high -> accepted every second cycle, resp_valid the cycle after each acceptance, req_ready=0 during RESP.
